hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 Parameter MCL_W, default 4: width of the multicycle-length field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rs1_32, rs2_32, rs1_16, rs2_16  input  5 each  source registers of the 32-bit and 16-bit slot instructions in ID.
REQ-006 rd_32_ex, rd_16_ex  input  5 each  destination registers of the slot instructions in EX.
REQ-007 memRead_32_ex, memRead_16_ex  input  1 each  the EX slot instruction is a load.
REQ-008 branch_taken_ex  input  1  branch in EX resolved taken.
REQ-009 mc_start_ex  input  1  multicycle (mul/div) op present in the 32-bit EX slot.
REQ-010 mc_len  input  MCL_W  EX occupancy of that op in cycles; 0 is treated as 1.
REQ-011 mem_req_mem, mem_ready  input  1 each  load/store in MEM; data memory ready.
REQ-012 perf_clr  input  1  synchronous clear of stall_cycles.
REQ-013 pc_en, ifid_en, idex_en, exmem_en  output  1 each  pipeline register write enables.
REQ-014 ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  output  1 each  load a NOP into both slots of the named register.
REQ-015 mc_busy  output  1  high while in MC_BUSY.
REQ-016 stall_cycles  output  CNT_W  count of cycles with pc_en=0.

Function
REQ-017 FSM states: RUN, MC_BUSY; 2-bit state register plus MCL_W-bit down-counter mc_cnt.
REQ-018 Control outputs are combinational from state, mc_cnt and inputs; defaults: all enables 1, all flush/bubble 0.
REQ-019 Memory stall (highest priority, any state): mem_req_mem=1 and mem_ready=0 -> pc_en, ifid_en, idex_en and exmem_en are 0, memwb_bubble=1, state and mc_cnt hold, and all lower-priority rules are ignored.
REQ-020 RUN, priority 2: branch_taken_ex=1 -> ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1.
REQ-021 RUN, priority 3: mc_start_ex=1 -> pc_en, ifid_en and idex_en are 0, exmem_bubble=1, mc_cnt<=len_eff-1 (len_eff = max(mc_len,1)), next state MC_BUSY.
REQ-022 MC_BUSY, mc_cnt!=0 -> same stall outputs as REQ-021, mc_cnt decrements; mc_start_ex is ignored.
REQ-023 MC_BUSY, mc_cnt=0 (release cycle) -> no multicycle stall, next state RUN; REQ-024 is evaluated this cycle; mc_start_ex and branch_taken_ex are ignored.
REQ-024 Load-use, priority 4: (memRead_x_ex=1, rd_x_ex!=0, rd_x_ex equal to any of the four ID sources, either slot x) -> pc_en=0, ifid_en=0, idex_bubble=1; state unchanged.
REQ-025 Register x0 never triggers a load-use stall.
REQ-026 Total stall for a multicycle op is exactly len_eff cycles, plus any memory-stall cycles that occur while it is in EX.
REQ-027 stall_cycles increments by 1 on each clock edge where pc_en=0 and saturates at all-ones.
REQ-028 perf_clr=1 zeroes stall_cycles and takes precedence over increment.
REQ-029 mc_busy = (state==MC_BUSY).

Reset
REQ-030 rst=1 asynchronously sets state=RUN, mc_cnt=0 and stall_cycles=0.
REQ-031 While rst=1, outputs are forced to: pc_en, ifid_en, idex_en and exmem_en = 1; all flush/bubble = 0; mc_busy=0.
REQ-032 Reset asserted in MC_BUSY aborts the op; after release the FSM is in RUN with no residual stall.

Verification
REQ-033 Load-use: memRead_16_ex=1, rd_16_ex=5, rs2_32=5 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1; next cycle (load gone) no stall; stall_cycles=1.
REQ-034 x0 load: memRead_32_ex=1, rd_32_ex=0, rs1_16=0 -> no stall.
REQ-035 Multicycle: mc_start_ex=1, mc_len=4 -> exmem_bubble high for 4 cycles, mc_busy high for 4 cycles, release on the 5th cycle; mc_len=0 -> 1 stall cycle.
REQ-036 Memory stall during MC_BUSY with mc_cnt=2: mem_ready=0 for 3 cycles -> all enables 0, memwb_bubble=1, mc_cnt holds at 2; total stall = 4+3 cycles.
REQ-037 Simultaneous branch_taken_ex and load-use -> flush wins: ifid_flush=1, idex_bubble=1, pc_en=1.
REQ-038 stall_cycles preset near all-ones -> saturates at 0xFFFF; perf_clr together with a stall cycle -> 0; rst mid-MC_BUSY -> RUN with all outputs at idle values.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard / stall controller for a dual-slot (32-bit + 16-bit) in-order pipeline.
// Resolves memory stalls, taken branches, multicycle EX ops and load-use
// hazards into pipeline register enables, flushes and bubbles, and counts
// the cycles in which the PC is held.
//
// Handshake note: the only handshake is the data-memory one. A MEM-stage
// request (mem_req_mem) completes in the cycle mem_ready is high. While a
// request is pending with mem_ready low, the whole front of the pipe holds
// and a bubble is written into MEM/WB.
module hazard_stall_controller #(
  parameter int CNT_W = 16,
  parameter int MCL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_32,
  input  logic [4:0]       rs2_32,
  input  logic [4:0]       rs1_16,
  input  logic [4:0]       rs2_16,
  input  logic [4:0]       rd_32_ex,
  input  logic [4:0]       rd_16_ex,
  input  logic             memRead_32_ex,
  input  logic             memRead_16_ex,
  input  logic             branch_taken_ex,
  input  logic             mc_start_ex,
  input  logic [MCL_W-1:0] mc_len,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MCL_W-1:0] r_mc_cnt;
  logic [MCL_W-1:0] w_mc_cnt_nxt;
  logic [MCL_W-1:0] w_len_m1;
  logic             w_mem_stall;
  logic             w_hit_32;
  logic             w_hit_16;
  logic             w_load_use;

  // Hazard detection terms; register x0 never produces a load-use hit.
  always_comb begin
    w_mem_stall = mem_req_mem && !mem_ready;
    w_hit_32    = memRead_32_ex && (rd_32_ex != 5'd0) &&
                  ((rd_32_ex == rs1_32) || (rd_32_ex == rs2_32) ||
                   (rd_32_ex == rs1_16) || (rd_32_ex == rs2_16));
    w_hit_16    = memRead_16_ex && (rd_16_ex != 5'd0) &&
                  ((rd_16_ex == rs1_32) || (rd_16_ex == rs2_32) ||
                   (rd_16_ex == rs1_16) || (rd_16_ex == rs2_16));
    w_load_use  = w_hit_32 || w_hit_16;
    // A zero length behaves as a one-cycle op, so the counter loads 0.
    w_len_m1    = (mc_len == '0) ? '0 : (mc_len - MCL_W'(1));
  end

  // FSM state register and multicycle down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // Next-state and control outputs, highest-priority rule first.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (rst) begin
      // Outputs stay at idle values while reset is held.
    end else if (w_mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (mc_start_ex) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            w_mc_cnt_nxt = w_len_m1;
            w_state_nxt  = ST_MC_BUSY;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          if (r_mc_cnt != '0) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            w_mc_cnt_nxt = r_mc_cnt - MCL_W'(1);
          end else begin
            // Release cycle: the op leaves EX; only load-use is still live.
            w_state_nxt = ST_RUN;
            if (w_load_use) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt  = ST_RUN;
          w_mc_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Saturating count of PC-hold cycles; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign mc_busy   = (r_state == ST_MC_BUSY);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. A second instance with a 4-bit
// counter shares all inputs so counter saturation is reached quickly.
module tb_hazard_stall_controller;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_32, rs2_32, rs1_16, rs2_16, rd_32_ex, rd_16_ex;
  logic       memRead_32_ex, memRead_16_ex, branch_taken_ex, mc_start_ex;
  logic [3:0] mc_len;
  logic       mem_req_mem, mem_ready, perf_clr;

  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, mc_busy;
  logic [15:0] stall_cycles;
  logic [1:0]  dbg_state;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en;
  logic        s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_memwb_bubble, s_mc_busy;
  logic [3:0]  s_stall_cycles;
  logic [1:0]  s_dbg_state;

  hazard_stall_controller #(.CNT_W(16), .MCL_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_32(rs1_32), .rs2_32(rs2_32), .rs1_16(rs1_16), .rs2_16(rs2_16),
    .rd_32_ex(rd_32_ex), .rd_16_ex(rd_16_ex),
    .memRead_32_ex(memRead_32_ex), .memRead_16_ex(memRead_16_ex),
    .branch_taken_ex(branch_taken_ex), .mc_start_ex(mc_start_ex), .mc_len(mc_len),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  hazard_stall_controller #(.CNT_W(4), .MCL_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .rs1_32(rs1_32), .rs2_32(rs2_32), .rs1_16(rs1_16), .rs2_16(rs2_16),
    .rd_32_ex(rd_32_ex), .rd_16_ex(rd_16_ex),
    .memRead_32_ex(memRead_32_ex), .memRead_16_ex(memRead_16_ex),
    .branch_taken_ex(branch_taken_ex), .mc_start_ex(mc_start_ex), .mc_len(mc_len),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .exmem_bubble(s_exmem_bubble), .memwb_bubble(s_memwb_bubble),
    .mc_busy(s_mc_busy), .stall_cycles(s_stall_cycles), .dbg_state(s_dbg_state)
  );

  // Control vector: {pc_en, ifid_en, idex_en, exmem_en,
  //                  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, mc_busy}
  logic [8:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en,
                ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, mc_busy};

  localparam logic [8:0] V_IDLE   = 9'b1111_0000_0;
  localparam logic [8:0] V_LU     = 9'b0011_0100_0;
  localparam logic [8:0] V_LU_B   = 9'b0011_0100_1;
  localparam logic [8:0] V_BR     = 9'b1111_1100_0;
  localparam logic [8:0] V_MC_RUN = 9'b0001_0010_0;
  localparam logic [8:0] V_MC_B   = 9'b0001_0010_1;
  localparam logic [8:0] V_REL    = 9'b1111_0000_1;
  localparam logic [8:0] V_MEM    = 9'b0000_0001_0;
  localparam logic [8:0] V_MEM_B  = 9'b0000_0001_1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int exp_sat   = 0;
  logic [8:0] exp_q[$];

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    rs1_32 = 5'd0; rs2_32 = 5'd0; rs1_16 = 5'd0; rs2_16 = 5'd0;
    rd_32_ex = 5'd0; rd_16_ex = 5'd0;
    memRead_32_ex = 1'b0; memRead_16_ex = 1'b0;
    branch_taken_ex = 1'b0; mc_start_ex = 1'b0; mc_len = 4'd0;
    mem_req_mem = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  // One clock: check the control vector mid-cycle, update the counter model,
  // then advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, {23'd0, ctl}, {23'd0, exp});
    if (perf_clr) begin
      exp_stall = 0;
      exp_sat   = 0;
    end else if (!exp[8]) begin
      if (exp_stall != 65535) exp_stall++;
      if (exp_sat != 15) exp_sat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt"}, {16'd0, stall_cycles}, exp_stall);
    check({tag, "_sat"}, {28'd0, s_stall_cycles}, exp_sat);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    // Inputs that would stall if reset did not force idle outputs.
    clr_inputs();
    mem_req_mem = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b1; mc_start_ex = 1'b1;
    @(negedge clk);
    check("rst_ctl", {23'd0, ctl}, {23'd0, V_IDLE});
    check("rst_cnt", {16'd0, stall_cycles}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    clr_inputs();
    exp_stall = 0;
    exp_sat   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    apply_reset();

    cycle("idle0", V_IDLE);
    check_cnt("idle0");

    // Load-use: 16-bit slot load feeding rs2_32.
    memRead_16_ex = 1'b1; rd_16_ex = 5'd5; rs2_32 = 5'd5;
    cycle("lu_16_rs2_32", V_LU);
    clr_inputs();
    cycle("lu_gone", V_IDLE);
    check_cnt("lu1");

    // Load-use: 32-bit slot load feeding rs1_16.
    memRead_32_ex = 1'b1; rd_32_ex = 5'd12; rs1_16 = 5'd12;
    cycle("lu_32_rs1_16", V_LU);
    // Mismatched register, and matching register without a load.
    memRead_32_ex = 1'b1; rd_32_ex = 5'd12; rs1_16 = 5'd13; rs2_16 = 5'd11;
    cycle("lu_nomatch", V_IDLE);
    memRead_32_ex = 1'b0; rd_32_ex = 5'd13;
    cycle("lu_noload", V_IDLE);
    // x0 load against x0 sources.
    clr_inputs();
    memRead_32_ex = 1'b1; rd_32_ex = 5'd0; rs1_16 = 5'd0;
    cycle("lu_x0", V_IDLE);
    check_cnt("lu2");

    // Branch together with load-use: flush wins.
    clr_inputs();
    branch_taken_ex = 1'b1; memRead_16_ex = 1'b1; rd_16_ex = 5'd7; rs1_32 = 5'd7;
    cycle("br_lu", V_BR);
    clr_inputs();

    // Multicycle op of length 4; start held two cycles to show it is ignored.
    exp_q = {V_MC_RUN, V_MC_B, V_MC_B, V_MC_B, V_REL, V_IDLE};
    for (int i = 0; i < 6; i++) begin
      mc_start_ex = (i < 2);
      mc_len = 4'd4;
      cycle($sformatf("mc4_c%0d", i), exp_q.pop_front());
    end
    clr_inputs();
    check_cnt("mc4");

    // Length 0: one stall cycle; release cycle still sees load-use only.
    mc_start_ex = 1'b1; mc_len = 4'd0;
    cycle("mc0_start", V_MC_RUN);
    branch_taken_ex = 1'b1; memRead_32_ex = 1'b1; rd_32_ex = 5'd9; rs2_16 = 5'd9;
    cycle("mc0_release_lu", V_LU_B);
    clr_inputs();
    cycle("mc0_after", V_IDLE);
    check_cnt("mc0");

    // Memory stall for 3 cycles while mc_cnt is 2 during a length-4 op.
    exp_q = {V_MC_RUN, V_MC_B, V_MEM_B, V_MEM_B, V_MEM_B, V_MC_B, V_MC_B, V_REL, V_IDLE};
    for (int i = 0; i < 9; i++) begin
      clr_inputs();
      mc_start_ex = (i == 0);
      mc_len = 4'd4;
      if (i >= 2 && i <= 4) begin
        mem_req_mem = 1'b1;
        mem_ready   = 1'b0;
      end
      cycle($sformatf("mc_mem_c%0d", i), exp_q.pop_front());
    end
    clr_inputs();
    check_cnt("mc_mem");

    // Memory stall in RUN beats a taken branch; ready memory does not stall.
    mem_req_mem = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b1;
    cycle("mem_run", V_MEM);
    mem_ready = 1'b1; branch_taken_ex = 1'b0;
    cycle("mem_ready", V_IDLE);
    clr_inputs();
    check_cnt("mem_run");

    // Clear together with a stall cycle.
    mem_req_mem = 1'b1; mem_ready = 1'b0; perf_clr = 1'b1;
    cycle("clr_stall", V_MEM);
    clr_inputs();
    check_cnt("clr");

    // Drive 20 stall cycles: small counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      mem_req_mem = 1'b1; mem_ready = 1'b0;
      cycle($sformatf("sat_c%0d", i), V_MEM);
    end
    clr_inputs();
    check_cnt("sat");

    // Reset in the middle of a multicycle op.
    mc_start_ex = 1'b1; mc_len = 4'd8;
    cycle("rmc_start", V_MC_RUN);
    mc_start_ex = 1'b0;
    cycle("rmc_busy", V_MC_B);
    #2 rst = 1'b1;
    exp_stall = 0;
    exp_sat   = 0;
    #1;
    check("rmc_rst_ctl", {23'd0, ctl}, {23'd0, V_IDLE});
    check("rmc_rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle("rmc_post0", V_IDLE);
    cycle("rmc_post1", V_IDLE);
    check("rmc_state", {30'd0, dbg_state}, 32'd0);
    check_cnt("rmc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
